// File: rtl/motion_sched_pkg.sv
// Shared constants, FSM state encodings and helpers for the motion AI scheduler.
package motion_sched_pkg;

  localparam int WINDOW_DEF  = 100;
  localparam int TIMEOUT_DEF = 4096;
  localparam int ARM_MAX     = 4;
  localparam int HYST_N      = 3;

  typedef logic [2:0] sched_state_t;

  localparam sched_state_t ST_IDLE    = 3'd0;
  localparam sched_state_t ST_START   = 3'd1;
  localparam sched_state_t ST_ARM     = 3'd2;
  localparam sched_state_t ST_RUN     = 3'd3;
  localparam sched_state_t ST_CAPTURE = 3'd4;
  localparam sched_state_t ST_WAIT    = 3'd5;
  localparam sched_state_t ST_RECOVER = 3'd6;

  // Saturating increment for the 2-bit alert streak counter.
  function automatic logic [1:0] streak_inc(input logic [1:0] s);
    return (s == 2'd3) ? s : s + 2'd1;
  endfunction

endpackage

// File: rtl/motion_sample_gate.sv
// Decimates the raw accelerometer stream and forwards at most WINDOW samples
// per analysis window through a single register stage.
module motion_sample_gate
  import motion_sched_pkg::*;
#(
  parameter int WINDOW = WINDOW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic [7:0]       decim_i,
  input  logic [2:0][15:0] sens_i,
  input  logic             sens_valid_i,
  output logic [2:0][15:0] accel_o,
  output logic             accel_valid_o
);

  localparam int FW = $clog2(WINDOW + 1);

  logic [7:0]    dec_q, dec_d;
  logic [FW-1:0] fwd_q, fwd_d;
  logic          take_d;
  logic          valid_q;

  always_comb begin
    dec_d  = dec_q;
    fwd_d  = fwd_q;
    take_d = 1'b0;
    if (clear_i) begin
      dec_d = 8'd0;
      fwd_d = '0;
    end else if (enable_i && sens_valid_i) begin
      dec_d = (dec_q >= decim_i) ? 8'd0 : dec_q + 8'd1;
      // Decimation phase keeps running after the window is full; excess samples drop.
      if (dec_q == 8'd0 && fwd_q < FW'(WINDOW)) begin
        take_d = 1'b1;
        fwd_d  = fwd_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q   <= 8'd0;
      fwd_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      dec_q   <= dec_d;
      fwd_q   <= fwd_d;
      valid_q <= take_d;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_axis
    logic [15:0] axis_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        axis_q <= 16'd0;
      end else if (take_d) begin
        axis_q <= sens_i[gi];
      end
    end
    assign accel_o[gi] = axis_q;
  end

  assign accel_valid_o = valid_q;

endmodule

// File: rtl/motion_ai_scheduler.sv
// Window sequencer for motion_ai_core: start, feed, capture, alert, hang recovery.
// Optional MOTION_SCHED_HYST_EN adds 3-window hysteresis on the alert output.
module motion_ai_scheduler
  import motion_sched_pkg::*;
#(
  parameter int WINDOW       = WINDOW_DEF,
  parameter int PERIOD_W     = 24,
  parameter int TIMEOUT      = TIMEOUT_DEF,
  parameter int CORE_RST_CYC = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_enable,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [7:0]          cfg_decim,
  input  logic [7:0]          cfg_thresh,
  input  logic [15:0]         sens_x,
  input  logic [15:0]         sens_y,
  input  logic [15:0]         sens_z,
  input  logic                sens_valid,
  output logic [15:0]         core_accel_x,
  output logic [15:0]         core_accel_y,
  output logic [15:0]         core_accel_z,
  output logic                core_accel_valid,
  output logic                core_start,
  output logic                core_rst_n,
  input  logic                core_busy,
  input  logic [31:0]         core_pattern,
  input  logic [7:0]          core_score,
  output logic [31:0]         res_pattern,
  output logic [7:0]          res_score,
  output logic                res_valid,
  output logic                alert,
  output logic                timeout_err,
  output logic [15:0]         win_count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  sched_state_t        state_q, state_d;
  logic                busy_q;
  logic [7:0]          decim_q, decim_d;
  logic [7:0]          thresh_q, thresh_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [7:0]          aux_q, aux_d;
  logic [31:0]         res_pattern_q;
  logic [7:0]          res_score_q;
  logic                res_valid_q;
  logic                alert_q, alert_d;
  logic                tmo_err_q;
  logic [15:0]         win_cnt_q;
  logic                score_hi;
  logic [2:0][15:0]    accel;

  always_comb begin
    state_d  = state_q;
    aux_d    = aux_q + 8'd1;
    tmo_d    = tmo_q;
    decim_d  = decim_q;
    thresh_d = thresh_q;
    // Period counter runs from START regardless of window progress.
    period_d = (period_q != '0) ? period_q - PERIOD_W'(1) : period_q;
    case (state_q)
      ST_IDLE: if (cfg_enable) state_d = ST_START;
      ST_START: begin
        decim_d  = cfg_decim;
        thresh_d = cfg_thresh;
        period_d = (cfg_period == '0) ? '0 : cfg_period - PERIOD_W'(1);
        tmo_d    = TW'(TIMEOUT);
        state_d  = ST_ARM;
      end
      ST_ARM: begin
        tmo_d = tmo_q - TW'(1);
        if (busy_q) state_d = ST_RUN;
        else if (tmo_q == TW'(1) || aux_q == 8'(ARM_MAX - 1)) state_d = ST_RECOVER;
      end
      ST_RUN: begin
        tmo_d = tmo_q - TW'(1);
        // busy_q was high on entry, so a low value here is the registered fall.
        if (!busy_q) state_d = ST_CAPTURE;
        else if (tmo_q == TW'(1)) state_d = ST_RECOVER;
      end
      ST_CAPTURE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (!cfg_enable) state_d = ST_IDLE;
        else if (period_q <= PERIOD_W'(1)) state_d = ST_START;
      end
      ST_RECOVER: if (aux_q == 8'(CORE_RST_CYC - 1)) state_d = ST_WAIT;
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q) aux_d = 8'd0;
  end

  assign score_hi = (core_score >= thresh_q);

`ifdef MOTION_SCHED_HYST_EN
  logic [1:0] streak_q, streak_d;
  logic       dir_q, dir_d;

  always_comb begin
    alert_d  = alert_q;
    streak_d = streak_q;
    dir_d    = dir_q;
    if (state_q == ST_CAPTURE) begin
      if (score_hi == dir_q) begin
        streak_d = streak_inc(streak_q);
      end else begin
        dir_d    = score_hi;
        streak_d = 2'd1;
      end
      if (streak_d >= 2'(HYST_N)) alert_d = score_hi;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= 2'd0;
      dir_q    <= 1'b0;
    end else begin
      streak_q <= streak_d;
      dir_q    <= dir_d;
    end
  end
`else
  always_comb begin
    alert_d = alert_q;
    if (state_q == ST_CAPTURE) alert_d = score_hi;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      busy_q        <= 1'b0;
      decim_q       <= 8'd0;
      thresh_q      <= 8'd0;
      period_q      <= '0;
      tmo_q         <= '0;
      aux_q         <= 8'd0;
      res_pattern_q <= 32'd0;
      res_score_q   <= 8'd0;
      res_valid_q   <= 1'b0;
      alert_q       <= 1'b0;
      tmo_err_q     <= 1'b0;
      win_cnt_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      busy_q      <= core_busy;
      decim_q     <= decim_d;
      thresh_q    <= thresh_d;
      period_q    <= period_d;
      tmo_q       <= tmo_d;
      aux_q       <= aux_d;
      alert_q     <= alert_d;
      res_valid_q <= (state_q == ST_CAPTURE);
      if (state_q == ST_CAPTURE) begin
        res_pattern_q <= core_pattern;
        res_score_q   <= core_score;
        win_cnt_q     <= win_cnt_q + 16'd1;
      end
      if (state_d == ST_RECOVER) tmo_err_q <= 1'b1;
    end
  end

  motion_sample_gate #(
    .WINDOW(WINDOW)
  ) u_gate (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (state_q == ST_RUN),
    .clear_i      (state_q == ST_START),
    .decim_i      (decim_q),
    .sens_i       ({sens_z, sens_y, sens_x}),
    .sens_valid_i (sens_valid),
    .accel_o      (accel),
    .accel_valid_o(core_accel_valid)
  );

  assign core_accel_x = accel[0];
  assign core_accel_y = accel[1];
  assign core_accel_z = accel[2];
  assign core_start   = (state_q == ST_START);
  assign core_rst_n   = (state_q != ST_RECOVER);
  assign res_pattern  = res_pattern_q;
  assign res_score    = res_score_q;
  assign res_valid    = res_valid_q;
  assign alert        = alert_q;
  assign timeout_err  = tmo_err_q;
  assign win_count    = win_cnt_q;

endmodule

// File: tb/tb_motion_ai_scheduler.sv
// Directed bench for motion_ai_scheduler: windows, decimation, alert, timeout, enable drop, reset.
module tb_motion_ai_scheduler;

`ifdef MOTION_SCHED_HYST_EN
  localparam logic HYST = 1'b1;
`else
  localparam logic HYST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_enable = 1'b0;
  logic [23:0] cfg_period = 24'd0;
  logic [7:0]  cfg_decim = 8'd0;
  logic [7:0]  cfg_thresh = 8'd0;
  logic [15:0] sens_x = 16'd0, sens_y = 16'd0, sens_z = 16'd0;
  logic        sens_valid = 1'b0;
  logic [15:0] core_accel_x, core_accel_y, core_accel_z;
  logic        core_accel_valid, core_start, core_rst_n;
  logic        core_busy = 1'b0;
  logic [31:0] core_pattern = 32'd0;
  logic [7:0]  core_score = 8'd0;
  logic [31:0] res_pattern;
  logic [7:0]  res_score;
  logic        res_valid, alert, timeout_err;
  logic [15:0] win_count;

  int checks = 0;
  int errors = 0;

  // Monitor counters, updated on the falling edge while outputs are stable.
  int   cyc = 0, acc_cnt = 0, start_cnt = 0, resv_cnt = 0, rstn_low_cnt = 0;
  int   last_start_cyc = 0, prev_start_cyc = 0, rec_entry_cyc = 0;
  logic rstn_prev = 1'b1;

  motion_ai_scheduler dut (
    .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_period(cfg_period),
    .cfg_decim(cfg_decim), .cfg_thresh(cfg_thresh),
    .sens_x(sens_x), .sens_y(sens_y), .sens_z(sens_z), .sens_valid(sens_valid),
    .core_accel_x(core_accel_x), .core_accel_y(core_accel_y), .core_accel_z(core_accel_z),
    .core_accel_valid(core_accel_valid), .core_start(core_start), .core_rst_n(core_rst_n),
    .core_busy(core_busy), .core_pattern(core_pattern), .core_score(core_score),
    .res_pattern(res_pattern), .res_score(res_score), .res_valid(res_valid),
    .alert(alert), .timeout_err(timeout_err), .win_count(win_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (core_accel_valid === 1'b1) acc_cnt = acc_cnt + 1;
    if (res_valid === 1'b1) resv_cnt = resv_cnt + 1;
    if (core_start === 1'b1) begin
      start_cnt      = start_cnt + 1;
      prev_start_cyc = last_start_cyc;
      last_start_cyc = cyc;
    end
    if (core_rst_n === 1'b0) begin
      rstn_low_cnt = rstn_low_cnt + 1;
      if (rstn_prev === 1'b1) rec_entry_cyc = cyc;
    end
    rstn_prev = core_rst_n;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag, input int max_cyc);
    int n = 0;
    while (core_start !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
    check(tag, {31'd0, core_start}, 32'd1);
  endtask

  task automatic wait_res(input string tag, input int max_cyc);
    int n = 0;
    while (res_valid !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
    check(tag, {31'd0, res_valid}, 32'd1);
  endtask

  // Raise busy on the start cycle and advance into RUN.
  task automatic enter_run();
    core_busy = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    int acc_before, resv_before, start_before;
    int n;

    repeat (3) tick();
    check("rst_core_rst_n", {31'd0, core_rst_n}, 32'd1);
    check("rst_core_start", {31'd0, core_start}, 32'd0);
    check("rst_accel_valid", {31'd0, core_accel_valid}, 32'd0);
    check("rst_outputs", {res_valid, alert, timeout_err, win_count, res_score}, 32'd0);

    // Window 1: decim 0, period 1000, 100 samples, score 95 vs thresh 80.
    cfg_decim = 8'd0; cfg_period = 24'd1000; cfg_thresh = 8'd80;
    rst = 1'b0; cfg_enable = 1'b1;
    wait_start("w1_start", 20);
    enter_run();
    for (int i = 0; i < 100; i++) begin
      sens_x = 16'(i * 3 + 1); sens_y = 16'(i + 16'h100); sens_z = 16'hF000;
      sens_valid = 1'b1;
      tick();
      if (i == 0) begin
        check("w1_first_valid", {31'd0, core_accel_valid}, 32'd1);
        check("w1_first_xyz", {core_accel_x, core_accel_y}, {16'd1, 16'h0100});
      end
    end
    sens_valid = 1'b0;
    cfg_decim = 8'd2; cfg_period = 24'd200;
    repeat (2) tick();
    check("w1_fwd_count", acc_cnt, 32'd100);
    core_pattern = 32'hCAFEBABE; core_score = 8'd95; core_busy = 1'b0;
    wait_res("w1_res_valid", 20);
    check("w1_pattern", res_pattern, 32'hCAFEBABE);
    check("w1_score", {24'd0, res_score}, 32'd95);
    check("w1_win_count", {16'd0, win_count}, 32'd1);
    check("w1_alert", {31'd0, alert}, HYST ? 32'd0 : 32'd1);
    tick();
    check("w1_res_pulse", {31'd0, res_valid}, 32'd0);

    // Window 2: decim 2, 330 samples -> 100 forwarded; score 20 clears alert.
    wait_start("w2_start", 2000);
    enter_run();
    check("w1_w2_period", last_start_cyc - prev_start_cyc, 32'd1000);
    check("w1_res_count", resv_cnt, 32'd1);
    acc_before = acc_cnt;
    cfg_period = 24'd6000; cfg_decim = 8'd0;
    for (int i = 0; i < 330; i++) begin
      sens_x = 16'(i); sens_valid = 1'b1;
      tick();
      if (i == 3) check("w2_decim_sample", {15'd0, core_accel_valid, core_accel_x}, {15'd0, 1'b1, 16'd3});
    end
    sens_valid = 1'b0;
    repeat (2) tick();
    check("w2_fwd_count", acc_cnt - acc_before, 32'd100);
    core_score = 8'd20; core_busy = 1'b0;
    wait_res("w2_res_valid", 20);
    check("w2_score", {24'd0, res_score}, 32'd20);
    check("w2_win_count", {16'd0, win_count}, 32'd2);
    check("w2_alert", {31'd0, alert}, 32'd0);

    // Window 3: busy never falls -> timeout recovery.
    wait_start("w3_start", 50);
    enter_run();
    resv_before = resv_cnt;
    n = 0;
    while (core_rst_n !== 1'b0 && n < 5000) begin
      tick();
      n++;
    end
    check("w3_rst_n_low", {31'd0, core_rst_n}, 32'd0);
    check("w3_timeout_err", {31'd0, timeout_err}, 32'd1);
    core_busy = 1'b0;
    repeat (4) tick();
    // START cycle plus 4096 counted ARM/RUN cycles.
    check("w3_timeout_cycles", rec_entry_cyc - last_start_cyc, 32'd4097);
    check("w3_rst_n_width", rstn_low_cnt, 32'd2);
    check("w3_rst_n_back", {31'd0, core_rst_n}, 32'd1);
    check("w3_no_res_valid", resv_cnt - resv_before, 32'd0);
    check("w3_win_count", {16'd0, win_count}, 32'd2);

    // Window 4: resumes at next period; enable dropped mid-RUN.
    wait_start("w4_start", 3000);
    enter_run();
    check("w3_w4_period", last_start_cyc - prev_start_cyc, 32'd6000);
    cfg_enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sens_x = 16'(i); sens_valid = 1'b1;
      tick();
    end
    sens_valid = 1'b0;
    core_pattern = 32'h12345678; core_score = 8'd90; core_busy = 1'b0;
    wait_res("w4_res_valid", 20);
    check("w4_pattern", res_pattern, 32'h12345678);
    check("w4_win_count", {16'd0, win_count}, 32'd3);
    check("w4_alert", {31'd0, alert}, HYST ? 32'd0 : 32'd1);
    start_before = start_cnt;
    repeat (30) tick();
    check("w4_no_restart", start_cnt - start_before, 32'd0);
    check("w4_timeout_sticky", {31'd0, timeout_err}, 32'd1);

    // Window 5: reset asserted mid-RUN.
    cfg_enable = 1'b1;
    wait_start("w5_start", 20);
    enter_run();
    sens_x = 16'hBEEF; sens_valid = 1'b1;
    tick();
    check("w5_valid_before_rst", {31'd0, core_accel_valid}, 32'd1);
    rst = 1'b1;
    tick();
    sens_valid = 1'b0; core_busy = 1'b0;
    check("w5_rst_accel_valid", {31'd0, core_accel_valid}, 32'd0);
    check("w5_rst_core_rst_n", {31'd0, core_rst_n}, 32'd1);
    check("w5_rst_core_start", {31'd0, core_start}, 32'd0);
    check("w5_rst_outputs", {res_valid, alert, timeout_err, win_count, res_score}, 32'd0);
    check("w5_rst_pattern", res_pattern, 32'd0);
    check("w5_rst_accel_x", {16'd0, core_accel_x}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
